spu32_cpu_decoder_pipe: RTL and testbench
=========================================

# spu32_cpu_decoder_pipe

Handshaked, parametrised instruction decoder for the spu32 core, sitting between instruction fetch and execute. It decodes each RV32I instruction into opcode, register indices, immediate, branch mask, ALU operation and bus operation. It optionally decodes the M extension and flags illegal encodings. A 2-entry skid buffer holds decoded results, so fetch and execute stall independently without a combinational ready path.

## Interface
Parameters:
- ENABLE_M, default 0: decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; when 0 these encodings are illegal.
- ALUOP_W, default 5: ALU op width; ALU op constants are defined for 5 bits.

Ports:
- I_clk  in  1  core clock.
- I_reset_n  in  1  asynchronous, active-low reset.
- I_instr  in  32  instruction word from fetch.
- I_valid  in  1  I_instr is valid.
- O_ready  out  1  decoder can accept; registered, equals "buffer has a free entry".
- I_flush  in  1  synchronous discard of all buffered entries (taken branch/trap).
- O_rs1, O_rs2  out  5 each  combinational I_instr[19:15] and I_instr[24:20], for regfile read during decode.
- O_valid  out  1  head entry is valid.
- I_ready  in  1  execute consumes head entry.
- O_rd, O_opcode  out  5 each  instr[11:7] and instr[6:2].
- O_funct3  out  3.
- O_imm  out  32  sign-extended immediate (S, B, U, J, I formats).
- O_branchmask  out  6  one-hot {BGEU,BLTU,BGE,BLT,BNE,BEQ}; 0 unless OP_BRANCH with a valid funct3.
- O_aluop  out  ALUOP_W.
- O_busop  out  3  load op for OP_LOAD, store op otherwise.
- O_illegal  out  1  head entry is an illegal instruction.

## Operation
- Accept: I_valid && O_ready. The decoded bundle {rd, opcode, funct3, imm, branchmask, aluop, busop, illegal} is written into the buffer tail the same edge.
- Pop: O_valid && I_ready. Outputs always reflect the head entry.
- Buffer: 2 entries, write/read pointers 1 bit wide, count 0..2.
  - Push and pop in the same cycle leave count unchanged.
  - At count 2, O_ready=0 and I_valid is ignored.
- aluop:
  - OP_OPIMM uses the funct3 table; SRAI is selected by funct7[5].
  - OP_OP uses funct7[5] for SUB/SRA.
  - OP_OP with funct7=0000001 and ENABLE_M=1 maps funct3 0..7 to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - All other opcodes produce ALUOP_ADD.
- Load busop: LB/LH/LW/LBU map to their ops; all other funct3 map to READHU. Stores: SB, SH, all other funct3 map to WRITEW.
- O_illegal=1 when any of the following holds:
  - instr[1:0]≠11.
  - opcode not in {LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OPIMM, MISCMEM, SYSTEM}.
  - BRANCH with funct3 ∈ {2,3}.
  - LOAD with funct3 ∈ {3,6,7}.
  - STORE with funct3 ≥3.
  - OP with funct7 ∉ {0000000, 0100000 (funct3 0/5 only)}, and also excluding 0000001 when ENABLE_M=1.
  - OPIMM shift with an illegal funct7.
- Illegal entries are still buffered and presented; execute raises the trap.
- Flush: count←0 and pointers←0 on the next edge. Flush beats a simultaneous accept (the input is dropped) and a simultaneous pop.

## Timing
- Latency: instruction accepted at edge N appears on O_* after edge N (O_valid=1 in cycle N+1 when the buffer was empty).
- Throughput: 1 instruction/cycle while I_ready=1.
- O_ready depends only on registered count. There is no I_ready→O_ready combinational path.
- Reset (asynchronous assert, synchronous deassert by the system):
  - count=0, O_valid=0, O_ready=0 during reset, O_ready=1 from the first edge after release.
  - Stored bundle fields reset to 0: O_imm=0, O_branchmask=0, O_aluop=0 (ALUOP_ADD), O_busop=0, O_illegal=0, O_rd=0, O_opcode=0, O_funct3=0.
- Reset mid-transfer discards all entries.
- O_rs1/O_rs2 are purely combinational from I_instr and are unaffected by reset.

## Structure
- Shared constants:
  - riscvdefs.vh: opcodes, funct3/funct7 values, including new FUNCT7_MULDIV.
  - aludefs.vh: 5-bit ALUOP_*, adding MUL..REMU at codes 16–23.
  - busdefs.vh: BUSOP_*.
- Sub-module spu32_cpu_decode_comb: the pure combinational instr→bundle function, parametrised by ENABLE_M.
- Top level owns the 2-entry buffer, pointers, count and flush.

## Test plan
- Reset, then 0x00500093 (addi x1,x0,5) with I_ready=1 → next cycle O_valid=1, opcode=00100, rd=1, imm=5, aluop=ADD, illegal=0.
- 0xFE208EE3 (beq x1,x2,-4) → imm=0xFFFFFFFC, branchmask=000001. 0x0020A423 (sw x2,8(x1)) → imm=8, busop=WRITEW.
- 0x022081B3 (mul x3,x1,x2): ENABLE_M=1 → aluop=MUL, illegal=0; ENABLE_M=0 → illegal=1.
- Hold I_ready=0 and present three valid instructions → two accepted, O_ready=0 after the second. Release I_ready → the instructions pop in order and the third is accepted once space frees.
- I_flush with I_valid=1 while count=2 → next cycle O_valid=0, count=0, input dropped.
- 0x00000000 and 0xFFFFFFFF → O_illegal=1; assert I_reset_n low mid-stream → O_valid=0 immediately.

Source files
------------

// File: rtl/spu32_cpu_decoder_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spu32_cpu_decoder_pipe_pkg
//  Purpose  : Shared RV32I/M opcode, funct3/funct7, ALU-op and bus-op
//             constants, plus the decoded bundle type for the decoder.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package spu32_cpu_decoder_pipe_pkg;

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OP_LOAD    = 5'b00000;
  localparam logic [4:0] OP_MISCMEM = 5'b00011;
  localparam logic [4:0] OP_OPIMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;
  localparam logic [4:0] OP_STORE   = 5'b01000;
  localparam logic [4:0] OP_OP      = 5'b01100;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_BRANCH  = 5'b11000;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_SYSTEM  = 5'b11100;

  // funct7 values
  localparam logic [6:0] FUNCT7_ZERO   = 7'b0000000;
  localparam logic [6:0] FUNCT7_SUB    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // funct3 values used by the decoder
  localparam logic [2:0] FUNCT3_ADD  = 3'd0;
  localparam logic [2:0] FUNCT3_SLL  = 3'd1;
  localparam logic [2:0] FUNCT3_SLT  = 3'd2;
  localparam logic [2:0] FUNCT3_SLTU = 3'd3;
  localparam logic [2:0] FUNCT3_XOR  = 3'd4;
  localparam logic [2:0] FUNCT3_SR   = 3'd5;
  localparam logic [2:0] FUNCT3_OR   = 3'd6;
  localparam logic [2:0] FUNCT3_AND  = 3'd7;

  // 5-bit ALU operations; the M-extension block occupies 16..23 so that
  // its low three bits equal funct3.
  localparam logic [4:0] ALUOP_ADD    = 5'd0;
  localparam logic [4:0] ALUOP_SUB    = 5'd1;
  localparam logic [4:0] ALUOP_AND    = 5'd2;
  localparam logic [4:0] ALUOP_OR     = 5'd3;
  localparam logic [4:0] ALUOP_XOR    = 5'd4;
  localparam logic [4:0] ALUOP_SLT    = 5'd5;
  localparam logic [4:0] ALUOP_SLTU   = 5'd6;
  localparam logic [4:0] ALUOP_SLL    = 5'd7;
  localparam logic [4:0] ALUOP_SRL    = 5'd8;
  localparam logic [4:0] ALUOP_SRA    = 5'd9;
  localparam logic [4:0] ALUOP_MUL    = 5'd16;
  localparam logic [4:0] ALUOP_MULH   = 5'd17;
  localparam logic [4:0] ALUOP_MULHSU = 5'd18;
  localparam logic [4:0] ALUOP_MULHU  = 5'd19;
  localparam logic [4:0] ALUOP_DIV    = 5'd20;
  localparam logic [4:0] ALUOP_DIVU   = 5'd21;
  localparam logic [4:0] ALUOP_REM    = 5'd22;
  localparam logic [4:0] ALUOP_REMU   = 5'd23;

  // Bus operations
  localparam logic [2:0] BUSOP_READB  = 3'd0;
  localparam logic [2:0] BUSOP_READBU = 3'd1;
  localparam logic [2:0] BUSOP_READH  = 3'd2;
  localparam logic [2:0] BUSOP_READHU = 3'd3;
  localparam logic [2:0] BUSOP_READW  = 3'd4;
  localparam logic [2:0] BUSOP_WRITEB = 3'd5;
  localparam logic [2:0] BUSOP_WRITEH = 3'd6;
  localparam logic [2:0] BUSOP_WRITEW = 3'd7;

  // One decoded instruction as held in the skid buffer
  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [5:0]  branchmask;
    logic [4:0]  aluop;
    logic [2:0]  busop;
    logic        illegal;
  } dec_bundle_t;

  // True for every major opcode the core implements
  function automatic logic opcode_known(input logic [4:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
      OP_OP, OP_OPIMM, OP_MISCMEM, OP_SYSTEM: opcode_known = 1'b1;
      default:                                opcode_known = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/spu32_cpu_decoder_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : spu32_cpu_decoder_pipe_if
//  Purpose  : Fetch-side and execute-side handshake bundle of the decoder.
//  Ports    : I_instr/I_valid/O_ready/I_flush/O_rs1/O_rs2 (fetch side),
//             O_valid/I_ready and decoded fields (execute side).
//             slave  = decoder view, master = surrounding pipeline view.
//  Revision : 1.0  initial release
// ============================================================================
interface spu32_cpu_decoder_pipe_if #(
  parameter int ALUOP_W = 5
);
  logic [31:0]        I_instr;
  logic               I_valid;
  logic               O_ready;
  logic               I_flush;
  logic [4:0]         O_rs1;
  logic [4:0]         O_rs2;
  logic               O_valid;
  logic               I_ready;
  logic [4:0]         O_rd;
  logic [4:0]         O_opcode;
  logic [2:0]         O_funct3;
  logic [31:0]        O_imm;
  logic [5:0]         O_branchmask;
  logic [ALUOP_W-1:0] O_aluop;
  logic [2:0]         O_busop;
  logic               O_illegal;

  modport slave (
    input  I_instr, I_valid, I_flush, I_ready,
    output O_ready, O_rs1, O_rs2, O_valid, O_rd, O_opcode, O_funct3,
           O_imm, O_branchmask, O_aluop, O_busop, O_illegal
  );

  modport master (
    output I_instr, I_valid, I_flush, I_ready,
    input  O_ready, O_rs1, O_rs2, O_valid, O_rd, O_opcode, O_funct3,
           O_imm, O_branchmask, O_aluop, O_busop, O_illegal
  );
endinterface
`default_nettype wire

// File: rtl/spu32_cpu_decode_comb.sv
`default_nettype none
// ============================================================================
//  Module   : spu32_cpu_decode_comb
//  Purpose  : Pure combinational RV32I(+M) instruction -> decoded bundle.
//  Ports    : instr  in  32  raw instruction word
//             bundle out     decoded fields (rd, opcode, funct3, imm,
//                            branchmask, aluop, busop, illegal)
//  Revision : 1.0  initial release
// ============================================================================
module spu32_cpu_decode_comb
  import spu32_cpu_decoder_pipe_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] instr,
  output dec_bundle_t bundle
);

  logic [4:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_is_muldiv;

  assign w_opcode = instr[6:2];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];

  // M-extension encodings only count as MUL/DIV when the extension exists;
  // otherwise they fall through to the illegal-funct7 check below.
  generate
    if (ENABLE_M) begin : g_muldiv
      assign w_is_muldiv = (w_opcode == OP_OP) && (w_funct7 == FUNCT7_MULDIV);
    end else begin : g_no_muldiv
      assign w_is_muldiv = 1'b0;
    end
  endgenerate

  always_comb begin
    bundle        = '0;
    bundle.rd     = instr[11:7];
    bundle.opcode = w_opcode;
    bundle.funct3 = w_funct3;

    // Immediate by format
    case (w_opcode)
      OP_LUI, OP_AUIPC: bundle.imm = {instr[31:12], 12'b0};
      OP_JAL:    bundle.imm = {{12{instr[31]}}, instr[19:12], instr[20],
                               instr[30:21], 1'b0};
      OP_BRANCH: bundle.imm = {{20{instr[31]}}, instr[7], instr[30:25],
                               instr[11:8], 1'b0};
      OP_STORE:  bundle.imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      default:   bundle.imm = {{21{instr[31]}}, instr[30:20]};
    endcase

    // Branch condition mask {BGEU,BLTU,BGE,BLT,BNE,BEQ}
    if (w_opcode == OP_BRANCH) begin
      case (w_funct3)
        3'd0:    bundle.branchmask = 6'b000001;
        3'd1:    bundle.branchmask = 6'b000010;
        3'd4:    bundle.branchmask = 6'b000100;
        3'd5:    bundle.branchmask = 6'b001000;
        3'd6:    bundle.branchmask = 6'b010000;
        3'd7:    bundle.branchmask = 6'b100000;
        default: bundle.branchmask = 6'b000000;
      endcase
    end

    // ALU operation; SUB only exists for register-register, SRA for both
    bundle.aluop = ALUOP_ADD;
    if ((w_opcode == OP_OPIMM) || (w_opcode == OP_OP)) begin
      case (w_funct3)
        FUNCT3_ADD:  bundle.aluop = ((w_opcode == OP_OP) && w_funct7[5])
                                    ? ALUOP_SUB : ALUOP_ADD;
        FUNCT3_SLL:  bundle.aluop = ALUOP_SLL;
        FUNCT3_SLT:  bundle.aluop = ALUOP_SLT;
        FUNCT3_SLTU: bundle.aluop = ALUOP_SLTU;
        FUNCT3_XOR:  bundle.aluop = ALUOP_XOR;
        FUNCT3_SR:   bundle.aluop = w_funct7[5] ? ALUOP_SRA : ALUOP_SRL;
        FUNCT3_OR:   bundle.aluop = ALUOP_OR;
        default:     bundle.aluop = ALUOP_AND;
      endcase
      // MUL..REMU are laid out so funct3 is the low three bits
      if (w_is_muldiv) begin
        bundle.aluop = {2'b10, w_funct3};
      end
    end

    // Bus operation: load table for loads, store table for everything else
    if (w_opcode == OP_LOAD) begin
      case (w_funct3)
        3'd0:    bundle.busop = BUSOP_READB;
        3'd1:    bundle.busop = BUSOP_READH;
        3'd2:    bundle.busop = BUSOP_READW;
        3'd4:    bundle.busop = BUSOP_READBU;
        default: bundle.busop = BUSOP_READHU;
      endcase
    end else begin
      case (w_funct3)
        3'd0:    bundle.busop = BUSOP_WRITEB;
        3'd1:    bundle.busop = BUSOP_WRITEH;
        default: bundle.busop = BUSOP_WRITEW;
      endcase
    end

    // Illegal-encoding detection
    bundle.illegal = 1'b0;
    if ((instr[1:0] != 2'b11) || !opcode_known(w_opcode)) begin
      bundle.illegal = 1'b1;
    end
    case (w_opcode)
      OP_BRANCH: if ((w_funct3 == 3'd2) || (w_funct3 == 3'd3)) bundle.illegal = 1'b1;
      OP_LOAD:   if ((w_funct3 == 3'd3) || (w_funct3 >= 3'd6)) bundle.illegal = 1'b1;
      OP_STORE:  if (w_funct3 >= 3'd3) bundle.illegal = 1'b1;
      OP_OP: begin
        if (!((w_funct7 == FUNCT7_ZERO) ||
              ((w_funct7 == FUNCT7_SUB) &&
               ((w_funct3 == FUNCT3_ADD) || (w_funct3 == FUNCT3_SR))) ||
              w_is_muldiv)) begin
          bundle.illegal = 1'b1;
        end
      end
      OP_OPIMM: begin
        if ((w_funct3 == FUNCT3_SLL) && (w_funct7 != FUNCT7_ZERO)) begin
          bundle.illegal = 1'b1;
        end
        if ((w_funct3 == FUNCT3_SR) &&
            (w_funct7 != FUNCT7_ZERO) && (w_funct7 != FUNCT7_SUB)) begin
          bundle.illegal = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/spu32_cpu_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : spu32_cpu_decoder_pipe
//  Purpose  : Handshaked instruction decoder with a 2-entry skid buffer
//             between fetch and execute.
//  Ports    : I_clk      in   core clock
//             I_reset_n  in   asynchronous active-low reset
//             bus        slave modport of spu32_cpu_decoder_pipe_if:
//                          fetch   : I_instr, I_valid, O_ready, I_flush,
//                                    O_rs1, O_rs2 (combinational)
//                          execute : O_valid, I_ready, O_rd, O_opcode,
//                                    O_funct3, O_imm, O_branchmask,
//                                    O_aluop, O_busop, O_illegal
//  Revision : 1.0  initial release
// ============================================================================
module spu32_cpu_decoder_pipe
  import spu32_cpu_decoder_pipe_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0,
  parameter int ALUOP_W  = 5
) (
  input  logic                      I_clk,
  input  logic                      I_reset_n,
  spu32_cpu_decoder_pipe_if.slave   bus
);

  dec_bundle_t w_dec;
  dec_bundle_t w_head;
  dec_bundle_t r_entry [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [1:0]  w_count_next;
  logic        r_ready;
  logic        w_push;
  logic        w_pop;

  spu32_cpu_decode_comb #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .instr  (bus.I_instr),
    .bundle (w_dec)
  );

  // Register indices bypass the buffer for the regfile read port
  assign bus.O_rs1 = bus.I_instr[19:15];
  assign bus.O_rs2 = bus.I_instr[24:20];

  assign w_push = bus.I_valid && r_ready;
  assign w_pop  = (r_count != 2'd0) && bus.I_ready;

  // Flush wins over any push or pop in the same cycle
  always_comb begin
    w_count_next = r_count;
    if (bus.I_flush) begin
      w_count_next = 2'd0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + 2'd1;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - 2'd1;
    end
  end

  // Ready is a flop fed from the next count, so execute's I_ready never
  // reaches O_ready combinationally; it is held low while in reset.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_ready  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_entry[i] <= '0;
      end
    end else begin
      r_count <= w_count_next;
      r_ready <= (w_count_next != 2'd2);
      if (bus.I_flush) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        if (w_push) begin
          r_entry[r_wr_ptr] <= w_dec;
          r_wr_ptr          <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
      end
    end
  end

  assign w_head = r_entry[r_rd_ptr];

  assign bus.O_ready      = r_ready;
  assign bus.O_valid      = (r_count != 2'd0);
  assign bus.O_rd         = w_head.rd;
  assign bus.O_opcode     = w_head.opcode;
  assign bus.O_funct3     = w_head.funct3;
  assign bus.O_imm        = w_head.imm;
  assign bus.O_branchmask = w_head.branchmask;
  assign bus.O_aluop      = ALUOP_W'(w_head.aluop);
  assign bus.O_busop      = w_head.busop;
  assign bus.O_illegal    = w_head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_spu32_cpu_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spu32_cpu_decoder_pipe
//  Purpose  : Directed self-checking bench for spu32_cpu_decoder_pipe,
//             one instance with the M extension and one without.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spu32_cpu_decoder_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  spu32_cpu_decoder_pipe_if #(.ALUOP_W(5)) bus_m ();
  spu32_cpu_decoder_pipe_if #(.ALUOP_W(5)) bus_n ();

  spu32_cpu_decoder_pipe #(.ENABLE_M(1'b1), .ALUOP_W(5)) dut (
    .I_clk     (clk),
    .I_reset_n (rst_n),
    .bus       (bus_m)
  );

  spu32_cpu_decoder_pipe #(.ENABLE_M(1'b0), .ALUOP_W(5)) dut_nom (
    .I_clk     (clk),
    .I_reset_n (rst_n),
    .bus       (bus_n)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [5:0]  bm;
    logic [4:0]  alu;
    logic [2:0]  busop;
    logic        ill;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus_m.I_instr = 32'h022081B3;
    @(negedge clk);
    checks++; if (bus_m.O_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus_m.O_valid); end
    checks++; if (bus_m.O_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", bus_m.O_ready); end
    checks++; if (bus_m.O_imm !== 32'h0) begin errors++; $display("FAIL rst_imm: got %h want 0", bus_m.O_imm); end
    checks++; if (bus_m.O_aluop !== 5'd0) begin errors++; $display("FAIL rst_aluop: got %0d want 0", bus_m.O_aluop); end
    checks++; if (bus_m.O_busop !== 3'd0) begin errors++; $display("FAIL rst_busop: got %0d want 0", bus_m.O_busop); end
    checks++; if (bus_m.O_illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b want 0", bus_m.O_illegal); end
    checks++; if (bus_m.O_rd !== 5'd0) begin errors++; $display("FAIL rst_rd: got %0d want 0", bus_m.O_rd); end
    checks++; if (bus_m.O_rs1 !== 5'd1) begin errors++; $display("FAIL rst_rs1: got %0d want 1", bus_m.O_rs1); end
    checks++; if (bus_m.O_rs2 !== 5'd2) begin errors++; $display("FAIL rst_rs2: got %0d want 2", bus_m.O_rs2); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus_m.O_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", bus_m.O_ready); end
    checks++; if (bus_m.O_valid !== 1'b0) begin errors++; $display("FAIL rel_valid: got %b want 0", bus_m.O_valid); end
  endtask

  task automatic test_addi();
    bus_m.I_ready = 1'b1;
    bus_m.I_instr = 32'h00500093;
    bus_m.I_valid = 1'b1;
    tick();
    bus_m.I_valid = 1'b0;
    checks++; if (bus_m.O_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", bus_m.O_valid); end
    checks++; if (bus_m.O_opcode !== 5'b00100) begin errors++; $display("FAIL addi_opcode: got %b want 00100", bus_m.O_opcode); end
    checks++; if (bus_m.O_rd !== 5'd1) begin errors++; $display("FAIL addi_rd: got %0d want 1", bus_m.O_rd); end
    checks++; if (bus_m.O_imm !== 32'd5) begin errors++; $display("FAIL addi_imm: got %h want 5", bus_m.O_imm); end
    checks++; if (bus_m.O_aluop !== 5'd0) begin errors++; $display("FAIL addi_aluop: got %0d want 0", bus_m.O_aluop); end
    checks++; if (bus_m.O_illegal !== 1'b0) begin errors++; $display("FAIL addi_illegal: got %b want 0", bus_m.O_illegal); end
    tick();
    checks++; if (bus_m.O_valid !== 1'b0) begin errors++; $display("FAIL addi_pop: got %b want 0", bus_m.O_valid); end
  endtask

  task automatic test_decode();
    vec_t v [8];
    //         instr         imm           bm         alu    busop ill
    v[0] = '{32'hFE208EE3, 32'hFFFFFFFC, 6'b000001, 5'd0, 3'd5, 1'b0}; // beq -4
    v[1] = '{32'h0020A423, 32'h00000008, 6'b000000, 5'd0, 3'd7, 1'b0}; // sw 8
    v[2] = '{32'h40208133, 32'h00000402, 6'b000000, 5'd1, 3'd5, 1'b0}; // sub
    v[3] = '{32'h4010D093, 32'h00000401, 6'b000000, 5'd9, 3'd7, 1'b0}; // srai
    v[4] = '{32'h0040C083, 32'h00000004, 6'b000000, 5'd0, 3'd1, 1'b0}; // lbu
    v[5] = '{32'h12345037, 32'h12345000, 6'b000000, 5'd0, 3'd7, 1'b0}; // lui
    v[6] = '{32'hFF9FF0EF, 32'hFFFFFFF8, 6'b000000, 5'd0, 3'd7, 1'b0}; // jal -8
    v[7] = '{32'h0020E863, 32'h00000010, 6'b010000, 5'd0, 3'd7, 1'b0}; // bltu +16
    bus_m.I_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_m.I_instr = v[i].instr;
      bus_m.I_valid = 1'b1;
      tick();
      bus_m.I_valid = 1'b0;
      checks++; if (bus_m.O_imm !== v[i].imm) begin errors++; $display("FAIL dec%0d_imm: got %h want %h", i, bus_m.O_imm, v[i].imm); end
      checks++; if (bus_m.O_branchmask !== v[i].bm) begin errors++; $display("FAIL dec%0d_bm: got %b want %b", i, bus_m.O_branchmask, v[i].bm); end
      checks++; if (bus_m.O_aluop !== v[i].alu) begin errors++; $display("FAIL dec%0d_aluop: got %0d want %0d", i, bus_m.O_aluop, v[i].alu); end
      checks++; if (bus_m.O_busop !== v[i].busop) begin errors++; $display("FAIL dec%0d_busop: got %0d want %0d", i, bus_m.O_busop, v[i].busop); end
      checks++; if (bus_m.O_illegal !== v[i].ill) begin errors++; $display("FAIL dec%0d_illegal: got %b want %b", i, bus_m.O_illegal, v[i].ill); end
      tick();
    end
  endtask

  task automatic test_muldiv();
    bus_m.I_ready = 1'b1;
    bus_n.I_ready = 1'b1;
    bus_m.I_instr = 32'h022081B3;
    bus_n.I_instr = 32'h022081B3;
    bus_m.I_valid = 1'b1;
    bus_n.I_valid = 1'b1;
    tick();
    bus_m.I_valid = 1'b0;
    bus_n.I_valid = 1'b0;
    checks++; if (bus_m.O_aluop !== 5'd16) begin errors++; $display("FAIL mul_aluop: got %0d want 16", bus_m.O_aluop); end
    checks++; if (bus_m.O_illegal !== 1'b0) begin errors++; $display("FAIL mul_illegal_m1: got %b want 0", bus_m.O_illegal); end
    checks++; if (bus_m.O_rd !== 5'd3) begin errors++; $display("FAIL mul_rd: got %0d want 3", bus_m.O_rd); end
    checks++; if (bus_n.O_valid !== 1'b1) begin errors++; $display("FAIL mul_valid_m0: got %b want 1", bus_n.O_valid); end
    checks++; if (bus_n.O_illegal !== 1'b1) begin errors++; $display("FAIL mul_illegal_m0: got %b want 1", bus_n.O_illegal); end
    // divu x3,x1,x2 (funct3=5) on the M-enabled instance
    bus_m.I_instr = 32'h0220D1B3;
    bus_m.I_valid = 1'b1;
    tick();
    bus_m.I_valid = 1'b0;
    checks++; if (bus_m.O_aluop !== 5'd21) begin errors++; $display("FAIL divu_aluop: got %0d want 21", bus_m.O_aluop); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [3];
    seq[0] = 32'h00700093;
    seq[1] = 32'h00800093;
    seq[2] = 32'h00900093;
    bus_m.I_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_m.I_instr = seq[i];
      bus_m.I_valid = 1'b1;
      tick();
      checks++; if (bus_m.O_imm !== 32'(7 + i)) begin errors++; $display("FAIL b2b%0d_imm: got %h want %h", i, bus_m.O_imm, 32'(7 + i)); end
      checks++; if (bus_m.O_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready: got %b want 1", i, bus_m.O_ready); end
    end
    bus_m.I_valid = 1'b0;
    tick();
    checks++; if (bus_m.O_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", bus_m.O_valid); end
  endtask

  task automatic test_backpressure();
    bus_m.I_ready = 1'b0;
    bus_m.I_instr = 32'h00100093;
    bus_m.I_valid = 1'b1;
    tick();
    checks++; if (bus_m.O_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", bus_m.O_ready); end
    bus_m.I_instr = 32'h00200093;
    tick();
    checks++; if (bus_m.O_ready !== 1'b0) begin errors++; $display("FAIL bp_ready2: got %b want 0", bus_m.O_ready); end
    checks++; if (bus_m.O_imm !== 32'd1) begin errors++; $display("FAIL bp_head_a: got %h want 1", bus_m.O_imm); end
    bus_m.I_instr = 32'h00300093;
    tick();
    checks++; if (bus_m.O_ready !== 1'b0) begin errors++; $display("FAIL bp_ready3: got %b want 0", bus_m.O_ready); end
    checks++; if (bus_m.O_imm !== 32'd1) begin errors++; $display("FAIL bp_hold_a: got %h want 1", bus_m.O_imm); end
    bus_m.I_ready = 1'b1;
    tick();
    checks++; if (bus_m.O_imm !== 32'd2) begin errors++; $display("FAIL bp_head_b: got %h want 2", bus_m.O_imm); end
    checks++; if (bus_m.O_ready !== 1'b1) begin errors++; $display("FAIL bp_ready4: got %b want 1", bus_m.O_ready); end
    tick();
    bus_m.I_valid = 1'b0;
    checks++; if (bus_m.O_imm !== 32'd3) begin errors++; $display("FAIL bp_head_c: got %h want 3", bus_m.O_imm); end
    checks++; if (bus_m.O_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c: got %b want 1", bus_m.O_valid); end
    tick();
    checks++; if (bus_m.O_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", bus_m.O_valid); end
  endtask

  task automatic test_flush();
    bus_m.I_ready = 1'b0;
    bus_m.I_instr = 32'h00100093;
    bus_m.I_valid = 1'b1;
    tick();
    bus_m.I_instr = 32'h00200093;
    tick();
    checks++; if (bus_m.O_ready !== 1'b0) begin errors++; $display("FAIL fl_full: got %b want 0", bus_m.O_ready); end
    bus_m.I_instr = 32'h00300093;
    bus_m.I_flush = 1'b1;
    bus_m.I_ready = 1'b1;
    tick();
    bus_m.I_flush = 1'b0;
    bus_m.I_valid = 1'b0;
    checks++; if (bus_m.O_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b want 0", bus_m.O_valid); end
    checks++; if (bus_m.O_ready !== 1'b1) begin errors++; $display("FAIL fl_ready: got %b want 1", bus_m.O_ready); end
    tick();
    checks++; if (bus_m.O_valid !== 1'b0) begin errors++; $display("FAIL fl_dropped: got %b want 0", bus_m.O_valid); end
    // After a flush the pointers restart: a fresh push must surface at once
    bus_m.I_instr = 32'h00400093;
    bus_m.I_valid = 1'b1;
    tick();
    bus_m.I_valid = 1'b0;
    checks++; if (bus_m.O_imm !== 32'd4) begin errors++; $display("FAIL fl_refill: got %h want 4", bus_m.O_imm); end
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] bad [7];
    bad[0] = 32'h00000000; // low bits 00
    bad[1] = 32'hFFFFFFFF; // unknown opcode
    bad[2] = 32'h80000033; // OP funct7 1000000
    bad[3] = 32'h0000B003; // LOAD funct3 3
    bad[4] = 32'h00002063; // BRANCH funct3 2
    bad[5] = 32'h0000B023; // STORE funct3 3
    bad[6] = 32'h40101093; // SLLI with funct7 0100000
    bus_m.I_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus_m.I_instr = bad[i];
      bus_m.I_valid = 1'b1;
      tick();
      bus_m.I_valid = 1'b0;
      checks++; if (bus_m.O_valid !== 1'b1) begin errors++; $display("FAIL ill%0d_valid: got %b want 1", i, bus_m.O_valid); end
      checks++; if (bus_m.O_illegal !== 1'b1) begin errors++; $display("FAIL ill%0d_flag: got %b want 1", i, bus_m.O_illegal); end
      tick();
    end
    checks++; if (bus_m.O_valid !== 1'b0) begin errors++; $display("FAIL ill_drain: got %b want 0", bus_m.O_valid); end
  endtask

  task automatic test_reset_midstream();
    bus_m.I_ready = 1'b0;
    bus_m.I_instr = 32'h00500093;
    bus_m.I_valid = 1'b1;
    tick();
    bus_m.I_valid = 1'b0;
    checks++; if (bus_m.O_valid !== 1'b1) begin errors++; $display("FAIL mr_pre: got %b want 1", bus_m.O_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_m.O_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b want 0", bus_m.O_valid); end
    checks++; if (bus_m.O_ready !== 1'b0) begin errors++; $display("FAIL mr_ready: got %b want 0", bus_m.O_ready); end
    checks++; if (bus_m.O_imm !== 32'h0) begin errors++; $display("FAIL mr_imm: got %h want 0", bus_m.O_imm); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus_m.O_ready !== 1'b1) begin errors++; $display("FAIL mr_rel_ready: got %b want 1", bus_m.O_ready); end
    checks++; if (bus_m.O_valid !== 1'b0) begin errors++; $display("FAIL mr_rel_valid: got %b want 0", bus_m.O_valid); end
  endtask

  initial begin
    bus_m.I_instr = 32'h0;
    bus_m.I_valid = 1'b0;
    bus_m.I_flush = 1'b0;
    bus_m.I_ready = 1'b1;
    bus_n.I_instr = 32'h0;
    bus_n.I_valid = 1'b0;
    bus_n.I_flush = 1'b0;
    bus_n.I_ready = 1'b1;

    test_reset();
    test_addi();
    test_decode();
    test_muldiv();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_midstream();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
